// File: rtl/ifetch_ctrl_if.sv
// Fetch-side bundle: instruction memory read port, decode handshake and redirect.
// master = fetch controller, slave = memory/decode environment.
interface ifetch_ctrl_if;
    typedef logic [31:0] word_t;

    word_t imem_addr;
    word_t imem_rdata;
    logic  out_valid;
    logic  out_ready;
    word_t out_pc;
    word_t out_instr;
    logic  redirect_valid;
    word_t redirect_pc;
    logic  misalign_err;
    logic  fetch_done;

    modport master (
        output imem_addr,
        input  imem_rdata,
        output out_valid,
        input  out_ready,
        output out_pc,
        output out_instr,
        input  redirect_valid,
        input  redirect_pc,
        output misalign_err,
        output fetch_done
    );

    modport slave (
        input  imem_addr,
        output imem_rdata,
        input  out_valid,
        output out_ready,
        input  out_pc,
        input  out_instr,
        output redirect_valid,
        output redirect_pc,
        input  misalign_err,
        input  fetch_done
    );
endinterface

// File: rtl/ifetch_ctrl.sv
// Instruction fetch controller: owns the fetch PC, captures combinational imem
// data into a small prefetch queue and hands {pc, instr} to decode.
module ifetch_ctrl #(
    parameter int unsigned DEPTH      = 2,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_BYTES = 32
) (
    input logic           clk,
    input logic           rst,
    ifetch_ctrl_if.master bus
);
    localparam int unsigned      PTR_W   = $clog2(DEPTH);
    localparam int unsigned      CNT_W   = PTR_W + 1;
    localparam logic [31:0]      LAST_PC = 32'(IMEM_BYTES - 4);
    localparam logic [CNT_W-1:0] FULL    = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             misalign_q, misalign_d;
    logic [31:0]      pc_mem_q    [DEPTH];
    logic [31:0]      instr_mem_q [DEPTH];

    logic redirect;
    logic pop;
    logic push;
    logic in_range;
    logic head_valid;

    always_comb begin
        head_valid = (count_q != '0);
        redirect   = bus.redirect_valid && (state_q != ST_BOOT);
        pop        = head_valid && bus.out_ready;
        in_range   = (fetch_pc_q <= LAST_PC);
        // A full queue still accepts a new word when the head leaves this cycle.
        push       = (state_q == ST_RUN) && !redirect && in_range &&
                     ((count_q < FULL) || pop);
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        misalign_d = 1'b0;

        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN:  if (!in_range) state_d = ST_DONE;
            ST_DONE: state_d = ST_DONE;
            default: state_d = ST_BOOT;
        endcase

        if (push) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end

        if (redirect) begin
            state_d    = ST_RUN;
            fetch_pc_d = {bus.redirect_pc[31:2], 2'b00};
            misalign_d = |bus.redirect_pc[1:0];
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;

        if (redirect) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_BOOT;
            fetch_pc_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            misalign_q <= misalign_d;
        end
    end

    // Storage needs no reset: entries are only observable while count_q covers them.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wr_ptr_q]    <= fetch_pc_q;
            instr_mem_q[wr_ptr_q] <= bus.imem_rdata;
        end
    end

    always_comb begin
        bus.imem_addr    = fetch_pc_q;
        bus.out_valid    = head_valid;
        bus.out_pc       = head_valid ? pc_mem_q[rd_ptr_q]    : '0;
        bus.out_instr    = head_valid ? instr_mem_q[rd_ptr_q] : '0;
        bus.misalign_err = misalign_q;
        bus.fetch_done   = (state_q == ST_DONE);
    end
endmodule

// File: tb/tb_ifetch_ctrl.sv
// Scoreboard bench for ifetch_ctrl: directed scenarios plus randomized
// ready/redirect/reset traffic checked against an in-order fetch-stream model.
module tb_ifetch_ctrl;
    localparam int unsigned DEPTH      = 2;
    localparam int unsigned IMEM_BYTES = 32;
    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] LAST_PC    = 32'(IMEM_BYTES - 4);

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Expected delivery order: PCs decode should still receive, oldest first.
    logic [31:0] exp_q [$];
    bit          pend_redir = 1'b0;
    logic [31:0] pend_pc    = '0;

    bit          hold       = 1'b0;
    logic [31:0] prev_pc    = '0;
    logic [31:0] prev_instr = '0;
    int          starve     = 0;
    logic [31:0] mon_e;

    ifetch_ctrl_if bus ();

    ifetch_ctrl #(
        .DEPTH      (DEPTH),
        .RESET_PC   (RESET_PC),
        .IMEM_BYTES (IMEM_BYTES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Memory image: word i holds 0x1000_0000 + i.
    assign bus.imem_rdata = 32'h1000_0000 + (bus.imem_addr >> 2);

    function automatic logic [31:0] word_at(input logic [31:0] pc);
        return 32'h1000_0000 + (pc >> 2);
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, expv);
        end
    endtask

    task automatic chkb(input string name, input logic got, input logic expv);
        checks++;
        if (got !== expv) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%b exp=%b", name, cyc, got, expv);
        end
    endtask

    function automatic void push_stream(input logic [31:0] start);
        logic [31:0] pc;
        pc = start;
        while (pc <= LAST_PC) begin
            exp_q.push_back(pc);
            pc = pc + 32'd4;
        end
    endfunction

    // Advance to #1 after the next edge; apply a redirect that took effect there.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (pend_redir) begin
            exp_q.delete();
            push_stream({pend_pc[31:2], 2'b00});
            pend_redir = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst                = 1'b1;
        bus.redirect_valid = 1'b0;
        pend_redir         = 1'b0;
        step();
        rst = 1'b0;
        exp_q.delete();
        push_stream(RESET_PC);
        cyc = 0;
    endtask

    task automatic redirect(input logic [31:0] pc, input bit taken);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = pc;
        pend_redir         = taken;
        pend_pc            = pc;
        step();
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!(bus.fetch_done && !bus.out_valid) && n < 40) begin
            step();
            n++;
        end
        chkb({name, "_done"}, bus.fetch_done && !bus.out_valid, 1'b1);
        chk({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: pops the scoreboard on every accepted head, checks stall stability.
    always @(negedge clk) begin
        if (rst) begin
            hold   = 1'b0;
            starve = 0;
        end else begin
            chkb("count_bound", dut.count_q <= DEPTH, 1'b1);
            if (hold) begin
                chkb("hold_valid", bus.out_valid, 1'b1);
                chk("hold_pc", bus.out_pc, prev_pc);
                chk("hold_instr", bus.out_instr, prev_instr);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected cyc=%0d got_pc=%h exp=none", cyc, bus.out_pc);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("sb_pc", bus.out_pc, mon_e);
                    chk("sb_instr", bus.out_instr, word_at(mon_e));
                end
            end
            hold       = bus.out_valid && !bus.out_ready && !bus.redirect_valid;
            prev_pc    = bus.out_pc;
            prev_instr = bus.out_instr;
            if (bus.redirect_valid) begin
                starve = 0;
            end else if (bus.out_ready && exp_q.size() != 0 && !bus.out_valid) begin
                starve++;
                chkb("no_starve", starve > 3, 1'b0);
                if (starve > 3) starve = 0;
            end else begin
                starve = 0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit          in_boot;
        logic [31:0] rpc;
        int          r;

        bus.out_ready      = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;

        // Streaming to end of memory, then redirect out of DONE.
        do_reset();
        chkb("rst_valid", bus.out_valid, 1'b0);
        chk("rst_pc", bus.out_pc, 32'h0);
        chk("rst_instr", bus.out_instr, 32'h0);
        chkb("rst_misalign", bus.misalign_err, 1'b0);
        chkb("rst_done", bus.fetch_done, 1'b0);
        chk("rst_addr", bus.imem_addr, RESET_PC);
        step();
        chkb("boot_latency", bus.out_valid, 1'b0);
        for (int k = 2; k <= 9; k++) begin
            step();
            chkb("stream_valid", bus.out_valid, 1'b1);
            chk("stream_pc", bus.out_pc, 32'((k - 2) * 4));
        end
        step();
        chkb("eom_done", bus.fetch_done, 1'b1);
        chkb("eom_valid", bus.out_valid, 1'b0);
        chk("eom_drained", 32'(exp_q.size()), 32'd0);
        redirect(32'h8, 1'b1);
        chkb("done_redir_clear", bus.fetch_done, 1'b0);
        chkb("done_redir_gap", bus.out_valid, 1'b0);
        step();
        chkb("done_redir_valid", bus.out_valid, 1'b1);
        chk("done_redir_pc", bus.out_pc, 32'h8);
        wait_done("done_redir");

        // Stall: queue fills with PC 0,4 and fetch holds at 8.
        bus.out_ready = 1'b0;
        do_reset();
        for (int i = 1; i <= 11; i++) begin
            step();
            if (i >= 2) begin
                chkb("stall_valid", bus.out_valid, 1'b1);
                chk("stall_pc", bus.out_pc, 32'h0);
            end
        end
        chk("stall_addr", bus.imem_addr, 32'h8);
        bus.out_ready = 1'b1;
        chk("release_pc0", bus.out_pc, 32'h0);
        step();
        chkb("release_valid1", bus.out_valid, 1'b1);
        chk("release_pc1", bus.out_pc, 32'h4);
        step();
        chkb("release_valid2", bus.out_valid, 1'b1);
        chk("release_pc2", bus.out_pc, 32'h8);
        wait_done("stall");

        // Redirect in the same cycle PC 4 is accepted.
        do_reset();
        step();
        step();
        chk("rp_pc0", bus.out_pc, 32'h0);
        step();
        chk("rp_pc4", bus.out_pc, 32'h4);
        redirect(32'h10, 1'b1);
        chkb("rp_gap", bus.out_valid, 1'b0);
        step();
        chkb("rp_valid", bus.out_valid, 1'b1);
        chk("rp_target", bus.out_pc, 32'h10);
        wait_done("redir_pop");

        // Misaligned target, then back-to-back redirects.
        do_reset();
        step();
        step();
        redirect(32'h0E, 1'b1);
        chkb("mis_pulse", bus.misalign_err, 1'b1);
        chkb("mis_gap", bus.out_valid, 1'b0);
        step();
        chkb("mis_clear", bus.misalign_err, 1'b0);
        chkb("mis_valid", bus.out_valid, 1'b1);
        chk("mis_target", bus.out_pc, 32'h0C);
        redirect(32'h4, 1'b1);
        redirect(32'h18, 1'b1);
        chkb("b2b_gap", bus.out_valid, 1'b0);
        chkb("b2b_no_mis", bus.misalign_err, 1'b0);
        step();
        chk("b2b_target", bus.out_pc, 32'h18);
        wait_done("b2b");

        // Redirect during BOOT is ignored.
        do_reset();
        redirect(32'h10, 1'b0);
        chkb("boot_redir_gap", bus.out_valid, 1'b0);
        step();
        chkb("boot_redir_valid", bus.out_valid, 1'b1);
        chk("boot_redir_pc", bus.out_pc, 32'h0);

        // Reset while the queue is full.
        bus.out_ready = 1'b0;
        step();
        step();
        chkb("full_before_rst", bus.out_valid, 1'b1);
        do_reset();
        chkb("midrst_valid", bus.out_valid, 1'b0);
        bus.out_ready = 1'b1;
        step();
        chkb("midrst_lat", bus.out_valid, 1'b0);
        step();
        chkb("midrst_valid2", bus.out_valid, 1'b1);
        chk("midrst_pc", bus.out_pc, RESET_PC);

        // Randomized ready / redirect / reset traffic.
        in_boot = 1'b0;
        for (int i = 0; i < 600; i++) begin
            r             = $urandom_range(0, 99);
            bus.out_ready = ($urandom_range(0, 9) < 7);
            if (r < 1) begin
                do_reset();
                in_boot = 1'b1;
                chkb("rnd_rst_valid", bus.out_valid, 1'b0);
            end else if (r < 8) begin
                rpc = 32'($urandom_range(0, 63));
                redirect(rpc, !in_boot);
                chkb("rnd_misalign", bus.misalign_err, !in_boot && (rpc[1:0] != 2'b00));
                in_boot = 1'b0;
            end else begin
                step();
                in_boot = 1'b0;
                chkb("rnd_no_misalign", bus.misalign_err, 1'b0);
            end
        end
        bus.out_ready = 1'b1;
        wait_done("rnd");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ifetch_ctrl.md
Name: ifetch_ctrl

Overview:
- Instruction fetch controller that sequences the byte-addressed instruction memory.
- Owns the fetch PC, drives the memory read address, and captures the combinational read data into a small prefetch queue.
- Presents {PC, instruction} to the decode stage over a valid/ready handshake.
- Handles stalls (ready low), control-flow redirects (branch/jump flush) and fetch past the end of memory.

Parameters:
- DEPTH, 2, prefetch queue entries; power of two, 2..8.
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset.
- IMEM_BYTES, 32, instruction memory size in bytes; valid fetch addresses are 0..IMEM_BYTES-4.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_addr  out  word_t  byte address to instruction memory; always equals fetch_pc.
- imem_rdata  in  word_t  instruction word at imem_addr; combinational, same cycle.
- out_valid  out  1  queue head holds a valid instruction.
- out_ready  in  1  decode accepts the head this cycle.
- out_pc  out  word_t  PC of the queue head.
- out_instr  out  word_t  instruction of the queue head.
- redirect_valid  in  1  flush and restart fetch at redirect_pc.
- redirect_pc  in  word_t  redirect target.
- misalign_err  out  1  one-cycle pulse: redirect target had bits [1:0] != 0.
- fetch_done  out  1  high while in state DONE.

Behaviour:
- Reset (rst=1 at an edge):
  - fetch_pc=RESET_PC; queue empty; state=BOOT.
  - out_valid=0, out_pc=0, out_instr=0, misalign_err=0, fetch_done=0.
  - Reset mid-operation discards all queued entries; the next redirect is ignored until reset is released.
- States:
  - BOOT: 1 cycle, no enqueue; then RUN.
  - RUN: fetching.
  - DONE: fetch_pc out of range; no enqueue; queue drains normally.
- Pop: out_valid && out_ready at an edge removes the head.
  - out_valid = (count != 0); out_pc/out_instr come from registered queue storage.
  - out_pc/out_instr hold stable while out_valid && !out_ready.
- Enqueue (RUN, no redirect): when (count < DEPTH) or a pop occurs the same cycle, push {fetch_pc, imem_rdata} and set fetch_pc += 4 (32-bit wrap).
  - Simultaneous push and pop when full is legal; count is unchanged.
- Latency: an instruction enqueued at edge N is visible (out_valid=1) in the cycle after edge N. First out_valid after reset release is at cycle 2 (BOOT, then enqueue at the end of cycle 1).
- Range check (RUN): if fetch_pc > IMEM_BYTES-4, no enqueue and state becomes DONE at that edge; fetch_done=1 from the next cycle.
- Redirect (redirect_valid=1 at edge N; any state except BOOT; highest priority):
  - A pop in cycle N still counts as consumed.
  - Queue is cleared and no enqueue occurs at edge N.
  - fetch_pc = {redirect_pc[31:2], 2'b00}; state = RUN.
  - Target enqueued at edge N+1; out_valid=1 with out_pc=target in cycle N+2.
  - If redirect_pc[1:0] != 0: misalign_err=1 for exactly cycle N+1; the aligned target is still used.
- Redirect asserted on consecutive cycles: each one flushes; only the last target survives.
- Redirect during BOOT: ignored.
- Queue pointers wrap modulo DEPTH; count range 0..DEPTH. No overflow or underflow is possible by construction; the bench asserts this.

Test Plan:
- Streaming: imem word i = 32'h1000_0000+i, out_ready=1 after reset → out_pc 0,4,8,… and out_instr 1000_0000,1000_0001,… on consecutive cycles starting at cycle 2; one instruction per cycle.
- Stall: out_ready=0 for 10 cycles → queue fills to DEPTH=2 (PC 0,4), fetch_pc holds 8, out_pc=0 stable. Release out_ready → 0,4,8 delivered with no gap or duplicate.
- Redirect with concurrent pop: in a cycle with head PC 4 accepted, redirect_pc=0x10 → PC 4 counted once; out_valid=0 in cycle N+1; out_pc=0x10 in cycle N+2.
- Misaligned redirect: redirect_pc=0x0E → misalign_err pulses one cycle; next delivered out_pc=0x0C.
- End of memory: IMEM_BYTES=32, out_ready=1 → PCs 0..0x1C delivered, then fetch_done=1, out_valid=0. A later redirect_pc=0x8 → fetch_done clears; PC 8 is delivered.
- Reset mid-stream: rst=1 for one cycle while the queue is full → out_valid=0 next cycle; fetch restarts at RESET_PC with first out_valid at cycle 2 after release.
